// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared FSM state type and active-low hex glyph table
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_HELD,
    ST_RELEASE_WAIT
  } btn_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {g,f,e,d,c,b,a}, active low; entry [0] is glyph "0"
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational 4-bit to active-low seven-segment decoder
module hex7seg
  import btn_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : SEG_GLYPHS[value];

endmodule

// File: rtl/nxt_btn_conditioner.sv
// rtl/nxt_btn_conditioner.sv - sync, debounce, press pulse/counter and HEX0 drive for nxt key
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module nxt_btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DB_CYCLES      = 500_000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_PERIOD  = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic [3:0] press_count,
  output logic [6:0] seg
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned MAX_RPT    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned MAX_CYCLES = (DB_CYCLES > MAX_RPT) ? DB_CYCLES : MAX_RPT;
`else
  // repeat parameters are inert in this build
  localparam int unsigned MAX_CYCLES = DB_CYCLES + 0 * (REPEAT_DELAY + REPEAT_PERIOD);
`endif
  localparam int CW = $clog2(MAX_CYCLES);

  logic          p, s1, s2;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_d, pulse_d;
  logic          db_done;

  assign p       = btn_raw ^ BTN_ACTIVE_LOW;
  assign db_done = (cnt_q == CW'(DB_CYCLES - 1));

`ifdef BTN_AUTOREPEAT_EN
  logic [CW-1:0] rpt_q, rpt_d;
  logic          rpt_armed_q, rpt_armed_d;
  logic          rpt_last;

  // first repeat waits the long delay, later ones the short period
  assign rpt_last = (rpt_q == (rpt_armed_q ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_q       <= '0;
      rpt_armed_q <= 1'b0;
    end else begin
      rpt_q       <= rpt_d;
      rpt_armed_q <= rpt_armed_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= 1'b0;
      s2          <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
      press_count <= 4'd0;
    end else begin
      s1          <= p;
      s2          <= s1;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      btn_level   <= level_d;
      press_pulse <= pulse_d;
      if (press_pulse) press_count <= press_count + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = btn_level;
    pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rpt_d       = '0;
    rpt_armed_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (s2) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s2) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (db_done) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HELD: begin
        if (!s2) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        else begin
          rpt_d       = rpt_last ? '0 : rpt_q + CW'(1);
          rpt_armed_d = rpt_armed_q | rpt_last;
          pulse_d     = rpt_last;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        if (s2) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (db_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  hex7seg u_hex0 (
    .value (press_count),
    .blank (1'b0),
    .seg   (seg)
  );

endmodule

// File: tb/tb_nxt_btn_conditioner.sv
// tb/tb_nxt_btn_conditioner.sv - self-checking bench for nxt_btn_conditioner (DB_CYCLES=8)
module tb_nxt_btn_conditioner;

  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic [3:0] press_count;
  logic [6:0] seg;

  int total = 0;
  int bad   = 0;

  int model_count = 0;
  int exp_q[$];
  logic chk_pending = 1'b0;
  int   chk_val = 0;

  int pulses_seen = 0;
  int level_lo = 0;
  int level_hi = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    int n_low;
    int exp_pulses;
  } vec_t;
  vec_t vecs[5];

  always #10 clk = ~clk;

  nxt_btn_conditioner #(
    .DB_CYCLES      (DB),
    .BTN_ACTIVE_LOW (1'b1),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .press_pulse (press_pulse),
    .press_count (press_count),
    .seg         (seg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    pulses_seen += int'(press_pulse);
    if (btn_level) level_hi++;
    else level_lo++;
  endtask

  task automatic expect_pulse;
    model_count = (model_count + 1) % 16;
    exp_q.push_back(model_count);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_level"}, 32'(btn_level), 0);
    check({tag, "_pulse"}, 32'(press_pulse), 0);
    check({tag, "_count"}, 32'(press_count), 0);
    check({tag, "_seg"}, 32'(seg), 32'(7'b1000000));
  endtask

  // scoreboard: each pulse pops the expected count, compared one cycle later
  always @(negedge clk) begin
    if (chk_pending) begin
      check("sb_count", 32'(press_count), 32'(chk_val));
      check("sb_seg", 32'(seg), 32'(glyph[chk_val[3:0]]));
    end
    chk_pending <= 1'b0;
    if (press_pulse) begin
      if (exp_q.size() == 0) check("unexpected_pulse", 32'(exp_q.size()), 1);
      else begin
        chk_val     <= exp_q.pop_front();
        chk_pending <= 1'b1;
      end
    end
  end

  initial begin
    int lat, rel, lvl_at, k0;
    int offs[$];

    vecs[0] = '{3, 0};
    vecs[1] = '{8, 0};
    vecs[2] = '{9, 1};
    vecs[3] = '{12, 1};
    vecs[4] = '{25, 1};

    rst = 1'b1;
    btn_raw = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // bounce: 5 low, 3 high, 4 low
    pulses_seen = 0; level_hi = 0;
    btn_raw = 1'b0; repeat (5) tick();
    btn_raw = 1'b1; repeat (3) tick();
    btn_raw = 1'b0; repeat (4) tick();
    btn_raw = 1'b1; repeat (30) tick();
    check("bounce_pulses", 32'(pulses_seen), 0);
    check("bounce_level", 32'(level_hi), 0);
    check("bounce_count", 32'(press_count), 0);

    // clean press: latency, width, release latency
    expect_pulse();
    pulses_seen = 0; lat = 0; lvl_at = 0;
    btn_raw = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (press_pulse && lat == 0) begin
        lat = k;
        lvl_at = int'(btn_level);
      end
    end
    check("press_latency", 32'(lat), 11);
    check("level_with_pulse", 32'(lvl_at), 1);
    check("pulse_width", 32'(pulses_seen), 1);
    btn_raw = 1'b1; rel = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!btn_level && rel == 0) rel = k;
    end
    check("release_latency", 32'(rel), 11);
    check("count_one", 32'(press_count), 1);
    check("seg_one", 32'(seg), 32'(7'b1111001));

    // table: low-stretch length around the debounce boundary
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_pulses != 0) expect_pulse();
      pulses_seen = 0;
      btn_raw = 1'b0; repeat (vecs[i].n_low) tick();
      btn_raw = 1'b1; repeat (30) tick();
      check($sformatf("vec%0d_low%0d_pulses", i, vecs[i].n_low), 32'(pulses_seen), 32'(vecs[i].exp_pulses));
    end

    // release glitch while held
    expect_pulse();
    btn_raw = 1'b0; repeat (20) tick();
    pulses_seen = 0; level_lo = 0;
    btn_raw = 1'b1; repeat (3) tick();
    btn_raw = 1'b0; repeat (20) tick();
    check("glitch_pulses", 32'(pulses_seen), 0);
    check("glitch_level_drop", 32'(level_lo), 0);
    btn_raw = 1'b1; rel = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!btn_level && rel == 0) rel = k;
    end
    check("glitch_release_latency", 32'(rel), 11);

    // wrap: 17 presses from zero
    rst = 1'b1; tick(); rst = 1'b0;
    model_count = 0;
    for (int i = 1; i <= 17; i++) begin
      expect_pulse();
      btn_raw = 1'b0; repeat (12) tick();
      btn_raw = 1'b1; repeat (30) tick();
      if (i == 15) begin
        check("count_15", 32'(press_count), 15);
        check("seg_15", 32'(seg), 32'(7'b0001110));
      end
    end
    check("wrap_count", 32'(press_count), 1);
    check("wrap_seg", 32'(seg), 32'(7'b1111001));

    // reset at PRESS_WAIT cnt=5 with key held
    btn_raw = 1'b0; repeat (8) tick();
    rst = 1'b1; tick();
    check_reset_outputs("midpress_reset");
    model_count = 0;
    rst = 1'b0;
    expect_pulse();
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (press_pulse && lat == 0) lat = k;
    end
    check("post_reset_latency", 32'(lat), 11);
    btn_raw = 1'b1; repeat (30) tick();

`ifdef BTN_AUTOREPEAT_EN
    rst = 1'b1; tick(); rst = 1'b0;
    model_count = 0;
    repeat (5) expect_pulse();
    btn_raw = 1'b0; k0 = 0;
    for (int k = 1; k <= 20 && k0 == 0; k++) begin
      tick();
      if (press_pulse) k0 = k;
    end
    check("rpt_first_latency", 32'(k0), 11);
    for (int k = 1; k <= 57; k++) begin
      tick();
      if (press_pulse) offs.push_back(k);
    end
    btn_raw = 1'b1; repeat (30) tick();
    check("rpt_pulse_count", 32'(offs.size()), 4);
    for (int i = 0; i < offs.size() && i < 4; i++)
      check($sformatf("rpt_offset%0d", i), 32'(offs[i]), 32'(20 + 10 * i));
    check("rpt_press_count", 32'(press_count), 5);
`else
    k0 = 0;
    offs.delete();
`endif

    repeat (5) tick();
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
